// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared command codes, sequencer state encodings and the state-to-command map
// used by the I2C register sequencer.
package i2c_reg_sequencer_pkg;

   localparam logic [2:0] k_START_CMD   = 3'd0;
   localparam logic [2:0] k_WRITE_CMD   = 3'd1;
   localparam logic [2:0] k_READ_CMD    = 3'd2;
   localparam logic [2:0] k_STOP_CMD    = 3'd3;
   localparam logic [2:0] k_RESTART_CMD = 3'd4;

   localparam logic [3:0] k_seq_IDLE    = 4'd0;
   localparam logic [3:0] k_seq_START   = 4'd1;
   localparam logic [3:0] k_seq_ADDR_W  = 4'd2;
   localparam logic [3:0] k_seq_REG     = 4'd3;
   localparam logic [3:0] k_seq_WDATA   = 4'd4;
   localparam logic [3:0] k_seq_RESTART = 4'd5;
   localparam logic [3:0] k_seq_ADDR_R  = 4'd6;
   localparam logic [3:0] k_seq_RDATA   = 4'd7;
   localparam logic [3:0] k_seq_STOP    = 4'd8;
   localparam logic [3:0] k_seq_RESP    = 4'd9;

   function automatic logic [2:0] f_state_cmd(input logic [3:0] i_state);
      case (i_state)
         k_seq_START:   f_state_cmd = k_START_CMD;
         k_seq_RESTART: f_state_cmd = k_RESTART_CMD;
         k_seq_RDATA:   f_state_cmd = k_READ_CMD;
         k_seq_STOP:    f_state_cmd = k_STOP_CMD;
         default:       f_state_cmd = k_WRITE_CMD;
      endcase
   endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Expands one single-byte register read/write into the I2C master command
// sequence, with slave-NACK reporting and a per-command completion timeout.
module i2c_reg_sequencer
   import i2c_reg_sequencer_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       resp_valid,
   output logic [7:0] resp_rdata,
   output logic       resp_err,
   output logic       resp_timeout,
   output logic [2:0] m_cmd,
   output logic [7:0] m_din,
   output logic       m_nack,
   output logic       m_wr,
   input  logic       m_ready,
   input  logic       m_done_tick,
   input  logic [7:0] m_dout,
   input  logic       m_ack
);

   logic [3:0]  r_state;
   logic        r_issued;
   logic [15:0] r_cnt;
   logic        r_rw;
   logic [6:0]  r_dev;
   logic [7:0]  r_reg;
   logic [7:0]  r_wdata;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [7:0]  r_resp_rdata;
   logic        r_resp_err;
   logic        r_resp_timeout;
   logic [2:0]  r_m_cmd;
   logic [7:0]  r_m_din;
   logic        r_m_nack;
   logic        r_m_wr;

   logic [3:0]  w_next;
   logic [7:0]  w_din;
   logic        w_nack_err;

   always_comb begin
      w_din = 8'hFF;
      case (r_state)
         k_seq_ADDR_W: w_din = {r_dev, 1'b0};
         k_seq_REG:    w_din = r_reg;
         k_seq_WDATA:  w_din = r_wdata;
         k_seq_ADDR_R: w_din = {r_dev, 1'b1};
         default:      w_din = 8'hFF;
      endcase
   end

   // The RDATA ack slot belongs to the master (NACK), so it is never an error.
   always_comb begin
      w_nack_err = 1'b0;
      case (r_state)
         k_seq_ADDR_W, k_seq_REG, k_seq_WDATA, k_seq_ADDR_R: w_nack_err = ~m_ack;
         default: w_nack_err = 1'b0;
      endcase
   end

   always_comb begin
      w_next = k_seq_IDLE;
      case (r_state)
         k_seq_START:   w_next = k_seq_ADDR_W;
         k_seq_ADDR_W:  w_next = w_nack_err ? k_seq_STOP : k_seq_REG;
         k_seq_REG:     w_next = w_nack_err ? k_seq_STOP : (r_rw ? k_seq_RESTART : k_seq_WDATA);
         k_seq_WDATA:   w_next = k_seq_STOP;
         k_seq_RESTART: w_next = k_seq_ADDR_R;
         k_seq_ADDR_R:  w_next = w_nack_err ? k_seq_STOP : k_seq_RDATA;
         k_seq_RDATA:   w_next = k_seq_STOP;
         k_seq_STOP:    w_next = k_seq_RESP;
         default:       w_next = k_seq_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= k_seq_IDLE;
         r_issued       <= 1'b0;
         r_cnt          <= 16'd0;
         r_rw           <= 1'b0;
         r_dev          <= 7'd0;
         r_reg          <= 8'd0;
         r_wdata        <= 8'd0;
         r_req_ready    <= 1'b1;
         r_resp_valid   <= 1'b0;
         r_resp_rdata   <= 8'd0;
         r_resp_err     <= 1'b0;
         r_resp_timeout <= 1'b0;
         r_m_cmd        <= k_START_CMD;
         r_m_din        <= 8'd0;
         r_m_nack       <= 1'b1;
         r_m_wr         <= 1'b0;
      end else begin
         r_m_wr       <= 1'b0;
         r_resp_valid <= 1'b0;
         case (r_state)
            k_seq_IDLE: begin
               if (req_valid) begin
                  r_req_ready    <= 1'b0;
                  r_rw           <= req_rw;
                  r_dev          <= req_dev;
                  r_reg          <= req_reg;
                  r_wdata        <= req_wdata;
                  r_resp_rdata   <= 8'd0;
                  r_resp_err     <= 1'b0;
                  r_resp_timeout <= 1'b0;
                  r_cnt          <= 16'd0;
                  r_state        <= k_seq_START;
                  // Issue START on the accept edge so it leaves one cycle later.
                  if (m_ready) begin
                     r_m_wr   <= 1'b1;
                     r_m_cmd  <= k_START_CMD;
                     r_m_din  <= 8'hFF;
                     r_m_nack <= 1'b1;
                     r_issued <= 1'b1;
                  end
               end
            end
            k_seq_START, k_seq_ADDR_W, k_seq_REG, k_seq_WDATA, k_seq_RESTART,
            k_seq_ADDR_R, k_seq_RDATA, k_seq_STOP: begin
               if (!r_issued) begin
                  if (m_ready) begin
                     r_m_wr   <= 1'b1;
                     r_m_cmd  <= f_state_cmd(r_state);
                     r_m_din  <= w_din;
                     r_m_nack <= 1'b1;
                     r_issued <= 1'b1;
                     r_cnt    <= 16'd0;
                  end
               end else if (m_done_tick) begin
                  r_issued <= 1'b0;
                  r_state  <= w_next;
                  if (w_nack_err)
                     r_resp_err <= 1'b1;
                  if (r_state == k_seq_RDATA)
                     r_resp_rdata <= m_dout;
                  if (r_state == k_seq_STOP)
                     r_resp_valid <= 1'b1;
               end else if (r_cnt == TIMEOUT) begin
                  // Master presumed hung: report without attempting a STOP.
                  r_issued       <= 1'b0;
                  r_resp_timeout <= 1'b1;
                  r_resp_rdata   <= 8'd0;
                  r_resp_valid   <= 1'b1;
                  r_state        <= k_seq_RESP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            k_seq_RESP: begin
               r_req_ready <= 1'b1;
               r_state     <= k_seq_IDLE;
            end
            default: begin
               r_issued    <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= k_seq_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = r_req_ready;
   assign resp_valid   = r_resp_valid;
   assign resp_rdata   = r_resp_rdata;
   assign resp_err     = r_resp_err;
   assign resp_timeout = r_resp_timeout;
   assign m_cmd        = r_m_cmd;
   assign m_din        = r_m_din;
   assign m_nack       = r_m_nack;
   assign m_wr         = r_m_wr;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: the bench plays the I2C master and
// checks command order, payload bytes, response flags and cycle timing.
module tb_i2c_reg_sequencer;

   localparam logic [2:0] C_START   = 3'd0;
   localparam logic [2:0] C_WRITE   = 3'd1;
   localparam logic [2:0] C_READ    = 3'd2;
   localparam logic [2:0] C_STOP    = 3'd3;
   localparam logic [2:0] C_RESTART = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rw = 1'b0;
   logic [6:0] req_dev = 7'd0;
   logic [7:0] req_reg = 8'd0;
   logic [7:0] req_wdata = 8'd0;
   logic       resp_valid;
   logic [7:0] resp_rdata;
   logic       resp_err;
   logic       resp_timeout;
   logic [2:0] m_cmd;
   logic [7:0] m_din;
   logic       m_nack;
   logic       m_wr;
   logic       m_ready = 1'b1;
   logic       m_done_tick = 1'b0;
   logic [7:0] m_dout = 8'd0;
   logic       m_ack = 1'b0;

   int checks = 0;
   int passes = 0;

   i2c_reg_sequencer #(.TIMEOUT(16'd16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_timeout(resp_timeout),
      .m_cmd(m_cmd), .m_din(m_din), .m_nack(m_nack), .m_wr(m_wr),
      .m_ready(m_ready), .m_done_tick(m_done_tick), .m_dout(m_dout), .m_ack(m_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; checks accept and whether START left at once.
   task automatic issue_req(input string tag, input logic rw, input logic [6:0] dev,
                            input logic [7:0] rg, input logic [7:0] wd,
                            input logic exp_wr, input logic hold);
      req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
      chk({tag, " ready_before"}, 16'(req_ready), 16'd1);
      tick();
      if (!hold) req_valid = 1'b0;
      chk({tag, " ready_drop"}, 16'(req_ready), 16'd0);
      chk({tag, " start_wr"}, 16'(m_wr), 16'(exp_wr));
   endtask

   // Wait (bounded) for the next strobe, check it, then optionally complete it.
   task automatic do_cmd(input string tag, input logic [2:0] cmd, input logic [7:0] din,
                         input logic ack, input logic [7:0] dout, input logic give_done);
      int n = 0;
      while (!m_wr && n < 50) begin
         tick();
         n++;
      end
      chk({tag, " wr_seen"}, 16'(m_wr), 16'd1);
      chk({tag, " cmd"}, 16'(m_cmd), 16'(cmd));
      chk({tag, " nack"}, 16'(m_nack), 16'd1);
      chk({tag, " busy"}, 16'(req_ready), 16'd0);
      if (cmd == C_WRITE || cmd == C_READ)
         chk({tag, " din"}, 16'(m_din), 16'(din));
      if (give_done) begin
         tick();
         chk({tag, " wr_single"}, 16'(m_wr), 16'd0);
         tick();
         chk({tag, " wr_hold"}, 16'(m_wr), 16'd0);
         m_done_tick = 1'b1; m_ack = ack; m_dout = dout;
         tick();
         m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
      end
   endtask

   task automatic chk_resp(input string tag, input logic [7:0] rdata, input logic err,
                           input logic to);
      chk({tag, " resp_valid"}, 16'(resp_valid), 16'd1);
      chk({tag, " resp_rdata"}, 16'(resp_rdata), 16'(rdata));
      chk({tag, " resp_err"}, 16'(resp_err), 16'(err));
      chk({tag, " resp_timeout"}, 16'(resp_timeout), 16'(to));
      tick();
      chk({tag, " resp_pulse"}, 16'(resp_valid), 16'd0);
      chk({tag, " ready_back"}, 16'(req_ready), 16'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " req_ready"}, 16'(req_ready), 16'd1);
      chk({tag, " resp_valid"}, 16'(resp_valid), 16'd0);
      chk({tag, " resp_rdata"}, 16'(resp_rdata), 16'd0);
      chk({tag, " resp_err"}, 16'(resp_err), 16'd0);
      chk({tag, " resp_timeout"}, 16'(resp_timeout), 16'd0);
      chk({tag, " m_cmd"}, 16'(m_cmd), 16'(C_START));
      chk({tag, " m_din"}, 16'(m_din), 16'd0);
      chk({tag, " m_nack"}, 16'(m_nack), 16'd1);
      chk({tag, " m_wr"}, 16'(m_wr), 16'd0);
   endtask

   initial begin
      repeat (3) tick();
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Write 0x50/0x10 <= 0xA5, all acked
      issue_req("wr", 1'b0, 7'h50, 8'h10, 8'hA5, 1'b1, 1'b0);
      do_cmd("wr start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("wr addr", C_WRITE, 8'hA0, 1'b1, 8'h00, 1'b1);
      do_cmd("wr reg", C_WRITE, 8'h10, 1'b1, 8'h00, 1'b1);
      do_cmd("wr data", C_WRITE, 8'hA5, 1'b1, 8'h00, 1'b1);
      do_cmd("wr stop", C_STOP, 8'h00, 1'b1, 8'h00, 1'b1);
      chk_resp("wr", 8'h00, 1'b0, 1'b0);

      // Read 0x50/0x22 -> 0x3C; master NACK on data byte is not an error
      issue_req("rd", 1'b1, 7'h50, 8'h22, 8'h77, 1'b1, 1'b0);
      do_cmd("rd start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("rd addrw", C_WRITE, 8'hA0, 1'b1, 8'h00, 1'b1);
      do_cmd("rd reg", C_WRITE, 8'h22, 1'b1, 8'h00, 1'b1);
      do_cmd("rd restart", C_RESTART, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("rd addrr", C_WRITE, 8'hA1, 1'b1, 8'h00, 1'b1);
      do_cmd("rd data", C_READ, 8'hFF, 1'b0, 8'h3C, 1'b1);
      do_cmd("rd stop", C_STOP, 8'h00, 1'b1, 8'h00, 1'b1);
      chk_resp("rd", 8'h3C, 1'b0, 1'b0);

      // Address NACK on a read: STOP immediately, error, no data
      issue_req("nak", 1'b1, 7'h2B, 8'h05, 8'h00, 1'b1, 1'b0);
      do_cmd("nak start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("nak addr", C_WRITE, 8'h56, 1'b0, 8'h99, 1'b1);
      do_cmd("nak stop", C_STOP, 8'h00, 1'b1, 8'h00, 1'b1);
      chk_resp("nak", 8'h00, 1'b1, 1'b0);

      // Timeout: REG never completes; 16 quiet cycles, then response, no STOP
      issue_req("to", 1'b0, 7'h11, 8'h33, 8'h44, 1'b1, 1'b0);
      do_cmd("to start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("to addr", C_WRITE, 8'h22, 1'b1, 8'h00, 1'b1);
      do_cmd("to reg", C_WRITE, 8'h33, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("to quiet_valid", 16'(resp_valid), 16'd0);
         chk("to quiet_wr", 16'(m_wr), 16'd0);
      end
      tick();
      chk("to no_stop", 16'(m_cmd), 16'(C_WRITE));
      chk_resp("to", 8'h00, 1'b0, 1'b1);
      chk("to no_stop_after", 16'(m_wr), 16'd0);

      // m_ready low for 5 cycles after accept; req_valid held through busy
      m_ready = 1'b0;
      issue_req("rdy", 1'b0, 7'h7F, 8'hFE, 8'h01, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rdy held_wr", 16'(m_wr), 16'd0);
         chk("rdy held_busy", 16'(req_ready), 16'd0);
      end
      m_ready = 1'b1;
      tick();
      chk("rdy start_now", 16'(m_wr), 16'd1);
      do_cmd("rdy start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("rdy addr", C_WRITE, 8'hFE, 1'b1, 8'h00, 1'b1);
      do_cmd("rdy reg", C_WRITE, 8'hFE, 1'b1, 8'h00, 1'b1);
      do_cmd("rdy data", C_WRITE, 8'h01, 1'b1, 8'h00, 1'b1);
      do_cmd("rdy stop", C_STOP, 8'h00, 1'b1, 8'h00, 1'b1);
      req_valid = 1'b0;
      chk_resp("rdy", 8'h00, 1'b0, 1'b0);
      tick();
      chk("rdy no_second", 16'(req_ready), 16'd1);

      // Reset while READ is outstanding, then a clean write
      issue_req("mr", 1'b1, 7'h50, 8'h22, 8'h00, 1'b1, 1'b0);
      do_cmd("mr start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("mr addrw", C_WRITE, 8'hA0, 1'b1, 8'h00, 1'b1);
      do_cmd("mr reg", C_WRITE, 8'h22, 1'b1, 8'h00, 1'b1);
      do_cmd("mr restart", C_RESTART, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("mr addrr", C_WRITE, 8'hA1, 1'b1, 8'h00, 1'b1);
      do_cmd("mr data", C_READ, 8'hFF, 1'b0, 8'h00, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk_reset_vals("mr rst");
      reset = 1'b0;
      tick();
      chk("mr idle_wr", 16'(m_wr), 16'd0);
      issue_req("post", 1'b0, 7'h05, 8'h80, 8'h5A, 1'b1, 1'b0);
      do_cmd("post start", C_START, 8'h00, 1'b1, 8'h00, 1'b1);
      do_cmd("post addr", C_WRITE, 8'h0A, 1'b1, 8'h00, 1'b1);
      do_cmd("post reg", C_WRITE, 8'h80, 1'b1, 8'h00, 1'b1);
      do_cmd("post data", C_WRITE, 8'h5A, 1'b1, 8'h00, 1'b1);
      do_cmd("post stop", C_STOP, 8'h00, 1'b1, 8'h00, 1'b1);
      chk_resp("post", 8'h00, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
